// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing the single synchronous maze memory port between two requesters.
// Define MAZE_ARB_STATS_EN to add saturating per-requester grant counters with a clear input.
module maze_port_arbiter #(
  parameter int maze_width = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [maze_width-1:0] row0,
  input  logic [maze_width-1:0] col0,
  input  logic [maze_width-1:0] row1,
  input  logic [maze_width-1:0] col1,
  input  logic                  we0,
  input  logic                  we1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rdata,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
`ifdef MAZE_ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           gcnt0,
  output logic [15:0]           gcnt1,
`endif
  input  logic                  maze_in
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state;
  logic       sel;
  logic       last;
  logic       we_q;
  logic       take;
  logic       win;

  // Only a tie consults the pointer; a lone requester always wins.
  always_comb begin
    take = req0 | req1;
    win  = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      we_q  <= 1'b0;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state <= ISSUE;
            sel   <= win;
            last  <= win;
            we_q  <= win ? we1 : we0;
            row   <= win ? row1 : row0;
            col   <= win ? col1 : col0;
          end
        end
        ISSUE:   state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0    = (state == ISSUE) && !sel;
  assign gnt1    = (state == ISSUE) && sel;
  assign maze_oe = (state == ISSUE) && !we_q;
  assign maze_we = (state == ISSUE) && we_q;
  assign rvalid0 = (state == WAIT) && !we_q && !sel;
  assign rvalid1 = (state == WAIT) && !we_q && sel;
  // Memory data is only forwarded while a read result is being returned.
  assign rdata   = maze_in & (rvalid0 | rvalid1);

`ifdef MAZE_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else if (stats_clr) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && (gcnt0 != 16'hFFFF)) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && (gcnt1 != 16'hFFFF)) gcnt1 <= gcnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Scoreboard bench for maze_port_arbiter: drivers queue expected accesses, a negedge monitor
// compares grants, addresses, read data and round-robin order against a reference memory.
module tb_maze_port_arbiter;
  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic         we;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [W-1:0] row0 = '0, col0 = '0, row1 = '0, col1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, rdata, maze_oe, maze_we, maze_in;
  logic [W-1:0] row, col;
`ifdef MAZE_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] gcnt0, gcnt1;
`endif

  maze_port_arbiter #(.maze_width(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we),
`ifdef MAZE_ARB_STATS_EN
    .stats_clr(stats_clr), .gcnt0(gcnt0), .gcnt1(gcnt1),
`endif
    .maze_in(maze_in)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic load = 1'b1;
  logic base_m  [64][64];
  logic mem     [64][64];
  logic ref_mem [64][64];
  acc_t exp_q0[$];
  acc_t exp_q1[$];
  int   gorder[$];
  int   gtime[$];
  logic due0 = 1'b0, due1 = 1'b0, post0 = 1'b0, post1 = 1'b0;
  logic ed0 = 1'b0, ed1 = 1'b0, p0 = 1'b0, p1 = 1'b0;
  int   last_g = 1;

  // Synchronous memory: read data appears the cycle after maze_oe; a write marks the cell.
  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++) mem[r][c] <= base_m[r][c];
      maze_in <= 1'b0;
    end else begin
      if (maze_oe) maze_in <= mem[row][col];
      if (maze_we) mem[row][col] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic grant(input int id);
    acc_t a;
    logic rd;
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_gnt%0d: got a grant, required none outstanding", id);
      return;
    end
    if (id == 0) a = exp_q0.pop_front();
    else a = exp_q1.pop_front();
    check($sformatf("gnt%0d_row", id), 32'(row), 32'(a.r));
    check($sformatf("gnt%0d_col", id), 32'(col), 32'(a.c));
    check($sformatf("gnt%0d_we", id), 32'(maze_we), 32'(a.we));
    check($sformatf("gnt%0d_oe", id), 32'(maze_oe), 32'(!a.we));
    if (p0 && p1) check("rr_winner", id, 1 - last_g);
    last_g = id;
    gorder.push_back(id);
    gtime.push_back(cyc);
    rd = ref_mem[a.r][a.c];
    if (a.we) ref_mem[a.r][a.c] = 1'b1;
    if (id == 0) begin
      post0 = 1'b1; due0 = !a.we; ed0 = rd;
    end else begin
      post1 = 1'b1; due1 = !a.we; ed1 = rd;
    end
  endtask

  // Monitor: sample away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q0.delete();
        exp_q1.delete();
        due0 = 1'b0; due1 = 1'b0; post0 = 1'b0; post1 = 1'b0;
        last_g = 1;
        check("rst_quiet", 32'({gnt0, gnt1, rvalid0, rvalid1, maze_oe, maze_we}), 32'd0);
      end else begin
        if (post0 || rvalid0) begin
          check("rvalid0", 32'(rvalid0), 32'(due0));
          if (rvalid0 && due0) check("rdata0", 32'(rdata), 32'(ed0));
        end
        if (post1 || rvalid1) begin
          check("rvalid1", 32'(rvalid1), 32'(due1));
          if (rvalid1 && due1) check("rdata1", 32'(rdata), 32'(ed1));
        end
        due0 = 1'b0; due1 = 1'b0; post0 = 1'b0; post1 = 1'b0;
        if (gnt0 || gnt1) begin
          check("gnt_onehot", 32'(gnt0 && gnt1), 32'd0);
          check("oe_we_excl", 32'(maze_oe && maze_we), 32'd0);
        end
        if (gnt0) grant(0);
        if (gnt1) grant(1);
      end
      p0 = req0;
      p1 = req1;
    end
  end

  task automatic drive(input int id, input logic [W-1:0] r, input logic [W-1:0] c,
                       input logic w);
    acc_t a;
    int   n;
    logic got;
    a.r = r; a.c = c; a.we = w;
    if (id == 0) begin
      exp_q0.push_back(a); row0 = r; col0 = c; we0 = w; req0 = 1'b1;
    end else begin
      exp_q1.push_back(a); row1 = r; col1 = c; we1 = w; req1 = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      got = (id == 0) ? gnt0 : gnt1;
    end
    // Worst case: own WAIT, then a full slot for the other side, then our own IDLE/ISSUE.
    check($sformatf("gnt%0d_latency_ok", id), 32'(got && n <= 6), 32'd1);
    @(posedge clk);
    #1;
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        base_m[r][c]  = 1'($urandom_range(0, 1));
        ref_mem[r][c] = base_m[r][c];
      end
    base_m[5][7] = 1'b1;
    ref_mem[5][7] = 1'b1;

    @(posedge clk);
    #1;
    load = 1'b0;
    check("reset_outputs",
          32'({gnt0, gnt1, rvalid0, rvalid1, maze_oe, maze_we, rdata, row, col}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_quiet",
            32'({gnt0, gnt1, rvalid0, rvalid1, maze_oe, maze_we, rdata, row, col}), 32'd0);
    end

    @(posedge clk);
    #1;
    drive(0, 6'd5, 6'd7, 1'b0);
    drive(1, 6'd63, 6'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Continuous contention: grants must alternate starting with 0, one per 3 cycles.
    gorder.delete();
    gtime.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) drive(0, 6'($urandom), 6'($urandom), 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) drive(1, 6'($urandom), 6'($urandom), 1'b0);
      end
    join
    check("alt_count", gorder.size(), 8);
    for (int k = 0; k < gorder.size(); k++) check("alt_order", gorder[k], k % 2);
    for (int k = 1; k < gtime.size(); k++) check("alt_period", gtime[k] - gtime[k-1], 3);
    repeat (3) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 25; i++) begin
          drive(0, 6'($urandom), 6'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          drive(1, 6'($urandom), 6'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("drained", exp_q0.size() + exp_q1.size(), 0);

    // Reset in the middle of an ISSUE cycle abandons the access.
    @(posedge clk);
    #1;
    begin
      acc_t a;
      int   n;
      logic got;
      a.r = 6'd9; a.c = 6'd9; a.we = 1'b0;
      exp_q0.push_back(a);
      row0 = 6'd9; col0 = 6'd9; we0 = 1'b0; req0 = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 12) begin
        @(negedge clk);
        n++;
        got = gnt0;
      end
      check("rst_test_gnt", 32'(got), 32'd1);
    end
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_issue", 32'({maze_oe, maze_we, gnt0, gnt1, row, col}), 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gorder.delete();
    gtime.delete();
    fork
      drive(0, 6'd1, 6'd2, 1'b0);
      drive(1, 6'd3, 6'd4, 1'b0);
    join
    check("post_rst_first", (gorder.size() > 0) ? gorder[0] : -1, 0);
    repeat (3) @(posedge clk);
    #1;

`ifdef MAZE_ARB_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    for (int i = 0; i < 5; i++) drive(0, 6'($urandom), 6'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) drive(1, 6'($urandom), 6'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("gcnt0", 32'(gcnt0), 32'd5);
    check("gcnt1", 32'(gcnt1), 32'd3);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("gcnt_clr", 32'({gcnt0, gcnt1}), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_port_arbiter.md
Name: maze_port_arbiter

Overview:
- Shares the single synchronous maze memory port (row, col, maze_oe, maze_we, maze_in) between two requesters.
- Requester 0 is the maze solver FSM; requester 1 is the host/loader or display scanner.
- Round-robin fairness with a fixed three-cycle access slot, so neither side can starve.
- Read data is returned to the granted requester only.

Parameters:
- maze_width, 6, width of the row and column indices.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request; held high until the matching gnt is seen
- row0, col0, row1, col1  in  maze_width  requested cell coordinates; stable while req is high
- we0, we1  in  1  1 = write (mark cell), 0 = read
- gnt0, gnt1  out  1  one-cycle pulse in the cycle the access is driven to memory
- rvalid0, rvalid1  out  1  one-cycle pulse; rdata is valid for this requester
- rdata  out  1  shared read data; equals maze_in while any rvalid is high
- row, col  out  maze_width  memory address
- maze_oe  out  1  memory read enable, synchronous
- maze_we  out  1  memory write enable, synchronous
- maze_in  in  1  memory read data; valid in the cycle after the memory samples maze_oe

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, all gnt/rvalid/maze_oe/maze_we=0, row=col=0, rdata=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- FSM, one access per three-cycle slot: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If no req, stay in IDLE.
  - If only one req is high, that requester wins.
  - If both are high, the requester != last wins.
  - At the edge: latch the winner's row, col and we into registers, set sel=winner, last=winner, go to ISSUE.
- ISSUE (exactly one cycle):
  - row/col = latched address; gnt[sel]=1.
  - Read: maze_oe=1, maze_we=0. Write: maze_we=1, maze_oe=0.
  - maze_oe and maze_we are never both high.
  - Always goes to WAIT.
- WAIT (exactly one cycle):
  - maze_oe=maze_we=0; row/col hold their value.
  - If the latched access was a read: rvalid[sel]=1 and rdata=maze_in. A write produces no rvalid.
  - The loser's req is ignored during this cycle; the winner's stale req is ignored because IDLE is entered only after the requester has dropped it.
  - Always goes to IDLE.
- Requester rule:
  - After sampling gnt=1 at an edge, the requester may either drop req or present a new request (new address/we).
  - The arbiter does not sample req in ISSUE or WAIT.
- Latency:
  - Uncontended request accepted in IDLE: gnt one cycle after acceptance, rvalid two cycles after.
  - Contended request: at most one extra slot (3 cycles) of wait.
- All outputs are driven from registered state; rdata is the only combinational path (maze_in to rdata).
- row/col hold the last issued address outside ISSUE/WAIT; there is no glitching to 0.
- req dropped before it is granted: the request is withdrawn and no grant is issued.
- Reset asserted mid-slot: the access is abandoned immediately, no gnt/rvalid is produced, outputs return to reset values, and the pointer is reset to last=1.

Optional Feature:
- Macro MAZE_ARB_STATS_EN.
- Defined:
  - Adds outputs gcnt0 and gcnt1 (16 bits each).
  - Each counter increments by 1 in every ISSUE cycle for its requester and saturates at 16'hFFFF.
  - Cleared by rst.
  - Adds input stats_clr (1 bit): a synchronous clear that takes precedence over an increment in the same cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, no reqs for 10 cycles -> all gnt/rvalid/maze_oe/maze_we stay 0, row=col=0.
- req0 read (row0=5, col0=7), memory cell (5,7)=1 -> gnt0 one cycle after acceptance with row=5, col=7, maze_oe=1; next cycle rvalid0=1, rdata=1; gnt1/rvalid1 stay 0.
- req1 write (row1=63, col1=0), held high -> gnt1 with maze_we=1, maze_oe=0 at row=63, col=0; no rvalid1 afterwards.
- req0 and req1 both held high continuously, reads -> grants alternate 0,1,0,1 starting with 0; one gnt every 3 cycles; each rvalid matches its gnt.
- rst asserted during ISSUE of a req0 read -> maze_oe drops immediately, no rvalid0; after release with both reqs high, first grant goes to 0.
- With MAZE_ARB_STATS_EN: 5 grants to 0 and 3 to 1 -> gcnt0=5, gcnt1=3; pulse stats_clr -> both read 0 next cycle.
